// File: rtl/hc_sr04.sv
// HC-SR04 ranging front end: fires the trigger pulse, times the echo in
// CLK_DIV-clock ticks and reports the width with a one-clock valid strobe.
module hc_sr04 #(
  parameter int CLK_DIV          = 500,
  parameter int TRIGGER_DURATION = 1,
  parameter int MAX_COUNT        = 3800,
  parameter int HOLDOFF          = 6000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        measure,
  input  logic        echo,
  output logic [15:0] ticks,
  output logic        valid,
  output logic        trigger
);

  localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [15:0]     MAX_C      = 16'(MAX_COUNT);
  localparam logic [15:0]     TRIG_LAST  = 16'(TRIGGER_DURATION - 1);
  localparam logic [15:0]     HOLD_LAST  = 16'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIGGER, S_WAIT_ECHO, S_MEASURE, S_DONE, S_HOLD
  } state_t;

  state_t          r_state, w_next;
  logic            r_echo_s1, r_echo_s2, r_echo_s3;
  logic [PW-1:0]   r_presc;
  logic [15:0]     r_cnt, r_phase_cnt, r_ticks, w_result;
  logic            r_trigger, r_valid;
  logic            w_tick, w_rise, w_fall;
  logic            w_presc_clr, w_cnt_clr, w_phase_clr;

  // NOTE: non-blocking assignments make the three flops a true shift chain;
  // blocking ones would collapse it into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_echo_s1 <= 1'b0;
      r_echo_s2 <= 1'b0;
      r_echo_s3 <= 1'b0;
    end else begin
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_s3 <= r_echo_s2;
    end
  end

  assign w_rise = r_echo_s2 & ~r_echo_s3;
  assign w_fall = ~r_echo_s2 & r_echo_s3;
  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_presc <= '0;
    else if (w_presc_clr || w_tick) r_presc <= '0;
    else                          r_presc <= r_presc + PW'(1);
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next      = r_state;
    w_result    = r_cnt;
    w_presc_clr = 1'b0;
    w_cnt_clr   = 1'b0;
    w_phase_clr = 1'b0;
    case (r_state)
      S_IDLE: if (measure) begin
        w_next      = S_TRIGGER;
        w_presc_clr = 1'b1;
        w_phase_clr = 1'b1;
      end
      S_TRIGGER: if (w_tick && r_phase_cnt == TRIG_LAST) begin
        w_next    = S_WAIT_ECHO;
        w_cnt_clr = 1'b1;
      end
      S_WAIT_ECHO: begin
        if (w_rise) begin
          w_next      = S_MEASURE;
          w_cnt_clr   = 1'b1;
          w_presc_clr = 1'b1;
        end else if (r_cnt == MAX_C) begin
          w_next      = S_DONE;
          w_result    = MAX_C;
          w_presc_clr = 1'b1;
        end
      end
      S_MEASURE: begin
        // A tick landing on the fall edge belongs to the pulse, giving floor().
        if (r_cnt == MAX_C) begin
          w_next      = S_DONE;
          w_result    = MAX_C;
          w_presc_clr = 1'b1;
        end else if (w_fall) begin
          w_next      = S_DONE;
          w_result    = r_cnt + 16'(w_tick);
          w_presc_clr = 1'b1;
        end
      end
      S_DONE: begin
        w_next      = S_HOLD;
        w_phase_clr = 1'b1;
      end
      S_HOLD: if (w_tick && r_phase_cnt == HOLD_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phase_cnt <= '0;
      r_trigger   <= 1'b0;
      r_valid     <= 1'b0;
      r_ticks     <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (w_tick && (r_state == S_WAIT_ECHO || r_state == S_MEASURE) && r_cnt != MAX_C)
        r_cnt <= r_cnt + 16'd1;
      if (w_phase_clr)
        r_phase_cnt <= '0;
      else if (w_tick && (r_state == S_TRIGGER || r_state == S_HOLD))
        r_phase_cnt <= r_phase_cnt + 16'd1;
      r_trigger <= (w_next == S_TRIGGER);
      r_valid   <= (w_next == S_DONE);
      if (w_next == S_DONE) r_ticks <= w_result;
    end
  end

  assign ticks   = r_ticks;
  assign valid   = r_valid;
  assign trigger = r_trigger;

endmodule

// File: tb/tb_hc_sr04.sv
// Self-checking bench for hc_sr04 with a scaled timebase: directed vectors,
// randomized echo widths against a tick-arithmetic model, and reset corners.
module tb_hc_sr04;

  localparam int D    = 5;
  localparam int TD   = 2;
  localparam int MAXC = 250;
  localparam int HO   = 10;
  localparam int HD   = HO * D;

  logic        clk = 1'b0, rst = 1'b1, measure = 1'b0, echo = 1'b0;
  logic [15:0] ticks;
  logic        valid, trigger;

  hc_sr04 #(.CLK_DIV(D), .TRIGGER_DURATION(TD), .MAX_COUNT(MAXC), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .measure(measure), .echo(echo),
    .ticks(ticks), .valid(valid), .trigger(trigger)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int val; } vev_t;
  typedef struct { int pre; int dly; int high; int exp; } vec_t;

  vev_t valid_q[$];
  vec_t tbl[10];
  int   pcyc = 0, last_rise = -1, dbl_valid = 0;
  logic valid_prev = 1'b0, trig_prev = 1'b0;
  int   n_cmp = 0, n_fail = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  // Observed at the falling edge, stamped with the number of rising edges seen.
  always @(negedge clk) begin
    if (valid) valid_q.push_back('{cyc: pcyc, val: int'(ticks)});
    if (valid && valid_prev) dbl_valid <= dbl_valid + 1;
    if (trigger && !trig_prev) last_rise <= pcyc;
    valid_prev <= valid;
    trig_prev  <= trigger;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int model_ticks(input int high);
    if (high == 0) return MAXC;
    return (high / D < MAXC) ? high / D : MAXC;
  endfunction

  // pf: edge the trigger fell; a: edge count when raw echo rose.
  function automatic int model_cyc(input int pf, input int a, input int high);
    if (high == 0)        return pf + MAXC * D + 1;
    if (high <= MAXC * D) return a + high + 3;
    return a + MAXC * D + 4;
  endfunction

  // Entered with the trigger just risen; ends once the result window has closed.
  task automatic run_echo(input int pre, input int dly, input int high, input int exp_ticks,
                          input bit drop_mid, input string name, output int vcyc);
    int pf, a, exp_cyc, end_cyc, n;
    valid_q.delete();
    if (pre > 0) echo = 1'b1;
    n = 0;
    while (trigger && n < TD * D + 10) begin step(); n++; end
    check({name, "_trig_width"}, pcyc - last_rise, TD * D);
    pf = pcyc;
    if (pre > 0) begin
      repeat (pre) step();
      echo = 1'b0;
    end
    repeat (dly) step();
    a = pcyc;
    if (high > 0) begin
      echo = 1'b1;
      for (int i = 0; i < high; i++) begin
        if (drop_mid && i == high / 2) measure = 1'b0;
        step();
      end
      echo = 1'b0;
    end
    exp_cyc = model_cyc(pf, a, high);
    end_cyc = ((exp_cyc > pcyc) ? exp_cyc : pcyc) + 2;
    while (pcyc < end_cyc) step();
    check({name, "_valid_count"}, valid_q.size(), 1);
    if (valid_q.size() > 0) begin
      check({name, "_valid_cycle"}, valid_q[0].cyc, exp_cyc);
      check({name, "_ticks"}, valid_q[0].val, exp_ticks);
    end
    check({name, "_ticks_hold"}, int'(ticks), exp_ticks);
    vcyc = exp_cyc;
  endtask

  task automatic next_trigger(input int vcyc, input string name);
    int n = 0;
    while (last_rise <= vcyc && n < HD + 20) begin step(); n++; end
    check_range(name, last_rise - vcyc, HD + 1, HD + 2);
  endtask

  initial begin
    int v, m, lr, n, dly, high;

    tbl[0] = '{pre: 0,  dly: 3, high: 0,    exp: 250};
    tbl[1] = '{pre: 0,  dly: 0, high: 4,    exp: 0};
    tbl[2] = '{pre: 0,  dly: 7, high: 5,    exp: 1};
    tbl[3] = '{pre: 0,  dly: 2, high: 9,    exp: 1};
    tbl[4] = '{pre: 0,  dly: 1, high: 1249, exp: 249};
    tbl[5] = '{pre: 0,  dly: 4, high: 1250, exp: 250};
    tbl[6] = '{pre: 0,  dly: 0, high: 1251, exp: 250};
    tbl[7] = '{pre: 0,  dly: 9, high: 1270, exp: 250};
    tbl[8] = '{pre: 20, dly: 5, high: 60,   exp: 12};
    tbl[9] = '{pre: 0,  dly: 2, high: 1,    exp: 0};

    #2 rst = 1'b0;
    measure = 1'b1;
    for (int i = 0; i < 8; i++) begin
      echo = 1'($urandom_range(0, 1));
      step();
      check("rst_trigger", int'(trigger), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_ticks", int'(ticks), 0);
    end
    echo = 1'b0;
    step();

    m = pcyc;
    rst = 1'b1;
    step();
    check("release_trigger_edge", last_rise, m + 1);

    run_echo(0, 40, 1000, 200, 1'b0, "basic", v);
    next_trigger(v, "basic_spacing");

    for (int i = 0; i < 10; i++) begin
      run_echo(tbl[i].pre, tbl[i].dly, tbl[i].high, tbl[i].exp, 1'b0,
               $sformatf("vec%0d", i), v);
      next_trigger(v, $sformatf("vec%0d_spacing", i));
    end

    for (int i = 0; i < 10; i++) begin
      dly  = int'($urandom_range(0, 20));
      high = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1280));
      run_echo(0, dly, high, model_ticks(high), 1'b0, $sformatf("rnd%0d_w%0d", i, high), v);
      next_trigger(v, $sformatf("rnd%0d_spacing", i));
    end

    run_echo(0, 5, 200, 40, 1'b1, "stop", v);
    lr = last_rise;
    repeat (HD + 30) step();
    check("stop_no_retrigger", last_rise, lr);
    check("stop_ticks_hold", int'(ticks), 40);

    m = pcyc;
    measure = 1'b1;
    step();
    check("idle_trigger_latency", last_rise, m + 1);
    n = 0;
    while (trigger && n < TD * D + 10) begin step(); n++; end
    echo = 1'b1;
    repeat (100) step();
    valid_q.delete();
    #2 rst = 1'b0;
    #1;
    check("abort_trigger", int'(trigger), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_ticks", int'(ticks), 0);
    echo = 1'b0;
    repeat (4) step();
    check("abort_no_valid", valid_q.size(), 0);
    m = pcyc;
    rst = 1'b1;
    step();
    check("abort_retrigger", last_rise, m + 1);
    measure = 1'b0;
    check("valid_never_double", dbl_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
